// File: rtl/x_conv_pkg.sv
// x_conv_pkg: shared types and constants for the x_conv frame scheduler.
//   sched_state_t  : scheduler FSM state encoding
//   filter_t       : 3x3 filter of 5-bit two's-complement coefficients, [row][col]
//   SOBEL_X_BASE   : Sobel-X kernel with unit brightness
//   BRIGHT_MIN/MAX : legal range of the middle-row scale
//   clamp_bright   : maps the raw 4-bit brightness into BRIGHT_MIN..BRIGHT_MAX
//   sobel_x_scaled : Sobel-X kernel with the middle row scaled by brightness
package x_conv_pkg;

    typedef enum logic [2:0] {
        SCHED_IDLE   = 3'd0,
        SCHED_LOAD   = 3'd1,
        SCHED_ISSUE  = 3'd2,
        SCHED_SETTLE = 3'd3,
        SCHED_WAIT   = 3'd4,
        SCHED_OUT    = 3'd5,
        SCHED_DONE   = 3'd6
    } sched_state_t;

    typedef logic [2:0][2:0][4:0] filter_t;

    localparam int BRIGHT_MIN = 1;
    localparam int BRIGHT_MAX = 7;

    // Rows are {1,0,-1}, {2,0,-2}, {1,0,-1}; element [r][0] is the leftmost tap.
    localparam filter_t SOBEL_X_BASE = {
        {5'b11111, 5'b00000, 5'b00001},
        {5'b11110, 5'b00000, 5'b00010},
        {5'b11111, 5'b00000, 5'b00001}
    };

    function automatic logic [2:0] clamp_bright(input logic [3:0] raw);
        if (raw < 4'(BRIGHT_MIN)) begin
            return 3'(BRIGHT_MIN);
        end
        if (raw > 4'(BRIGHT_MAX)) begin
            return 3'(BRIGHT_MAX);
        end
        return raw[2:0];
    endfunction

    // 2*b is at most 14, so +/-2*b always fits in 5-bit two's complement.
    function automatic filter_t sobel_x_scaled(input logic [2:0] b);
        filter_t    f;
        logic [4:0] two_b;
        f       = SOBEL_X_BASE;
        two_b   = {1'b0, b, 1'b0};
        f[1][0] = two_b;
        f[1][2] = 5'd0 - two_b;
        return f;
    endfunction

endpackage

// File: rtl/conv_window_counter.sv
// conv_window_counter: raster-order window position counter.
//   Steps col by STRIDE until the next window would not fit, then wraps col
//   and steps row. Only full 3x3 windows are ever produced.
// Ports:
//   clk, n_rst : clock, async active-low reset
//   clear      : restart at window (0,0)
//   advance    : move to the next window (ignored on the last window)
//   row, col   : top-left corner of the current window
//   last       : current window is the final one of the frame
module conv_window_counter
    import x_conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 9,
    parameter int IMG_HEIGHT = 9,
    parameter int STRIDE     = 3,
    localparam int RW = $clog2(IMG_HEIGHT),
    localparam int CW = $clog2(IMG_WIDTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic col_end;
    logic row_end;

    // A step fits only if the window starting there still ends inside the image.
    assign col_end = (int'(col) + STRIDE + 3) > IMG_WIDTH;
    assign row_end = (int'(row) + STRIDE + 3) > IMG_HEIGHT;
    assign last    = col_end && row_end;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance && !last) begin
            if (col_end) begin
                col <= '0;
                row <= RW'(int'(row) + STRIDE);
            end else begin
                col <= CW'(int'(col) + STRIDE);
            end
        end
    end

endmodule

// File: rtl/x_conv_sched.sv
// x_conv_sched: walks the x_conv datapath over one image frame, one 3x3
// window at a time in raster order, and forwards each result downstream.
// Optional feature macro: X_CONV_SCHED_TIMEOUT_EN (WAIT timeout + timeout_err).
// Ports:
//   clk, n_rst           : clock, async active-low reset
//   start, brightness    : frame start (IDLE only), middle-row scale latched on start
//   busy                 : frame in progress (LOAD..OUT)
//   win_row, win_col     : current window address to the pixel buffer
//   calc_enable, filter  : one-cycle compute strobe and coefficients to x_conv
//   calc_done, conv      : x_conv completion and result
//   result_valid/ready   : downstream handshake
//   result_data/row/col  : captured conv and its window tag
//   frame_done           : one-cycle pulse after the last result is taken
//   timeout_err          : sticky WAIT timeout flag (macro builds only)
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | pixel buffer fetches the window at win_row/win_col
// ISSUE  | calc_enable pulse
// SETTLE | one dead cycle so a stale calc_done level is not taken
// WAIT   | waiting for calc_done (or timeout), captures the result
// OUT    | result_valid held until result_ready
// DONE   | frame_done pulse
module x_conv_sched
    import x_conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 9,
    parameter int IMG_HEIGHT = 9,
    parameter int STRIDE     = 3,
    parameter int TIMEOUT    = 16,
    localparam int RW = $clog2(IMG_HEIGHT),
    localparam int CW = $clog2(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [3:0]            brightness,
    output logic                  busy,
    output logic [RW-1:0]         win_row,
    output logic [CW-1:0]         win_col,
    output logic                  calc_enable,
    output logic [2:0][2:0][4:0]  filter,
    input  logic                  calc_done,
    input  logic [9:0]            conv,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [9:0]            result_data,
    output logic [RW-1:0]         result_row,
    output logic [CW-1:0]         result_col,
`ifdef X_CONV_SCHED_TIMEOUT_EN
    output logic                  timeout_err,
`endif
    output logic                  frame_done
);

    if (IMG_WIDTH < 3 || IMG_HEIGHT < 3 || STRIDE < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("x_conv_sched: illegal parameter value");
    end

    localparam logic [2:0] S_IDLE   = SCHED_IDLE;
    localparam logic [2:0] S_LOAD   = SCHED_LOAD;
    localparam logic [2:0] S_ISSUE  = SCHED_ISSUE;
    localparam logic [2:0] S_SETTLE = SCHED_SETTLE;
    localparam logic [2:0] S_WAIT   = SCHED_WAIT;
    localparam logic [2:0] S_OUT    = SCHED_OUT;
    localparam logic [2:0] S_DONE   = SCHED_DONE;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] bright_q;
    logic       start_acc;
    logic       win_adv;
    logic       win_last;
    logic       wait_expired;

    assign start_acc = (state == S_IDLE) && start;
    assign win_adv   = (state == S_OUT) && result_ready;

    conv_window_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .STRIDE     (STRIDE)
    ) u_win (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (start_acc),
        .advance (win_adv),
        .row     (win_row),
        .col     (win_col),
        .last    (win_last)
    );

`ifdef X_CONV_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Loaded in SETTLE so WAIT sees TIMEOUT-1 down to 0: exactly TIMEOUT WAIT cycles.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tmo_cnt <= '0;
        end else if (state == S_SETTLE) begin
            tmo_cnt <= TW'(TIMEOUT - 1);
        end else if (state == S_WAIT && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign wait_expired = (state == S_WAIT) && !calc_done && (tmo_cnt == '0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timeout_err <= 1'b0;
        end else if (start_acc) begin
            timeout_err <= 1'b0;
        end else if (wait_expired) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_WAIT;
            S_WAIT:   if (calc_done || wait_expired) state_nxt = S_OUT;
            S_OUT:    if (result_ready) state_nxt = win_last ? S_DONE : S_LOAD;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bright_q <= 3'(BRIGHT_MIN);
        end else if (start_acc) begin
            bright_q <= clamp_bright(brightness);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            result_data <= '0;
            result_row  <= '0;
            result_col  <= '0;
        end else if (state == S_WAIT && calc_done) begin
            result_data <= conv;
            result_row  <= win_row;
            result_col  <= win_col;
        end else if (wait_expired) begin
            result_data <= '0;
            result_row  <= win_row;
            result_col  <= win_col;
        end
    end

    assign filter       = sobel_x_scaled(bright_q);
    assign busy         = (state != S_IDLE) && (state != S_DONE);
    assign calc_enable  = (state == S_ISSUE);
    assign result_valid = (state == S_OUT);
    assign frame_done   = (state == S_DONE);

endmodule

// File: tb/tb_x_conv_sched.sv
// Testbench for x_conv_sched: a stand-in x_conv answers each calc_enable,
// a window-list model predicts addresses, results and filter every cycle.
module tb_x_conv_sched;
    import x_conv_pkg::*;

    localparam int W    = 9;
    localparam int H    = 9;
    localparam int S    = 3;
    localparam int NC   = (W - 3) / S + 1;
    localparam int NR   = (H - 3) / S + 1;
    localparam int NWIN = NC * NR;

    logic                 clk = 1'b0;
    logic                 n_rst = 1'b0;
    logic                 start = 1'b0;
    logic [3:0]           brightness = 4'd0;
    logic                 busy;
    logic [3:0]           win_row;
    logic [3:0]           win_col;
    logic                 calc_enable;
    logic [2:0][2:0][4:0] filter;
    logic                 calc_done;
    logic [9:0]           conv;
    logic                 result_valid;
    logic                 result_ready = 1'b1;
    logic [9:0]           result_data;
    logic [3:0]           result_row;
    logic [3:0]           result_col;
    logic                 frame_done;
`ifdef X_CONV_SCHED_TIMEOUT_EN
    logic                 timeout_err;
`endif

    x_conv_sched #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .STRIDE(S), .TIMEOUT(16)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .brightness   (brightness),
        .busy         (busy),
        .win_row      (win_row),
        .win_col      (win_col),
        .calc_enable  (calc_enable),
        .filter       (filter),
        .calc_done    (calc_done),
        .conv         (conv),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_data  (result_data),
        .result_row   (result_row),
        .result_col   (result_col),
`ifdef X_CONV_SCHED_TIMEOUT_EN
        .timeout_err  (timeout_err),
`endif
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int row_of(input int k);
        return (k / NC) * S;
    endfunction

    function automatic int col_of(input int k);
        return (k % NC) * S;
    endfunction

    function automatic logic [9:0] conv_of(input int k);
        return 10'((k * 37 + 5) % 1024);
    endfunction

    function automatic int model_bright(input int raw);
        if (raw == 0) return 1;
        if (raw > 7) return 7;
        return raw;
    endfunction

    function automatic filter_t model_filter(input int b);
        filter_t f;
        int      coef;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                coef = (c == 0) ? 1 : ((c == 1) ? 0 : -1);
                if (r == 1) coef = coef * 2 * b;
                f[r][c] = 5'(coef);
            end
        end
        return f;
    endfunction

    // ---------------- stand-in x_conv ----------------
    int lat  = 2;
    bit hang = 1'b0;

    initial begin : xconv_stub
        int issue_idx;
        int cd_cnt;
        issue_idx = 0;
        cd_cnt    = 0;
        calc_done = 1'b0;
        conv      = '0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                cd_cnt    = 0;
                calc_done = 1'b0;
                issue_idx = 0;
            end else begin
                if (start && !busy && !frame_done) issue_idx = 0;
                if (calc_enable) begin
                    cd_cnt    = hang ? 0 : lat;
                    calc_done = 1'b0;
                    conv      = conv_of(issue_idx);
                    issue_idx++;
                end else if (cd_cnt > 0) begin
                    cd_cnt--;
                    calc_done = (cd_cnt == 0);
                end else begin
                    calc_done = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int         en_idx = 0;
    int         res_idx = 0;
    int         frames = 0;
    int         cur_b = 1;
    logic       prev_en = 1'b0;
    logic       prev_hold = 1'b0;
    logic [9:0] prev_data;
    logic [3:0] prev_row;
    logic [3:0] prev_col;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                en_idx    = 0;
                res_idx   = 0;
                cur_b     = 1;
                prev_en   = 1'b0;
                prev_hold = 1'b0;
            end else begin
                chk("filter", filter, model_filter(cur_b));
                if (calc_enable) begin
                    chk("enable_width", prev_en, 1'b0);
                    chk("enable_during_result", result_valid, 1'b0);
                    chk("busy_at_enable", busy, 1'b1);
                    chk("win_row", win_row, row_of(en_idx));
                    chk("win_col", win_col, col_of(en_idx));
                    en_idx++;
                end
                if (prev_hold) begin
                    chk("hold_valid", result_valid, 1'b1);
                    chk("hold_data", result_data, prev_data);
                    chk("hold_row", result_row, prev_row);
                    chk("hold_col", result_col, prev_col);
                end
                if (result_valid && result_ready) begin
                    chk("result_data", result_data, hang ? 10'd0 : conv_of(res_idx));
                    chk("result_row", result_row, row_of(res_idx));
                    chk("result_col", result_col, col_of(res_idx));
                    res_idx++;
                end
                if (frame_done) begin
                    chk("frame_done_after_last", res_idx, NWIN);
                    chk("busy_at_done", busy, 1'b0);
                    frames++;
                end
                prev_en   = calc_enable;
                prev_hold = result_valid && !result_ready;
                prev_data = result_data;
                prev_row  = result_row;
                prev_col  = result_col;
                if (start && !busy && !frame_done) begin
                    cur_b   = model_bright(int'(brightness));
                    en_idx  = 0;
                    res_idx = 0;
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic start_frame(input logic [3:0] b);
        @(posedge clk);
        #1 start = 1'b1;
        brightness = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_frame(input int target);
        for (int i = 0; i < 2000 && frames < target; i++) @(posedge clk);
        chk("frame_timeout", 64'(frames >= target), 1);
    endtask

    task automatic wait_valid();
        int i;
        for (i = 0; i < 200 && !result_valid; i++) @(negedge clk);
        chk("valid_timeout", 64'(result_valid), 1);
    endtask

    initial begin : main
        int seen;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_calc_enable", calc_enable, 0);
        chk("reset_result_valid", result_valid, 0);
        chk("reset_result_data", result_data, 0);
        chk("reset_win", {win_row, win_col}, 0);
        chk("reset_tags", {result_row, result_col}, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_filter", filter, {5'b11111, 5'b00000, 5'b00001,
                                     5'b11110, 5'b00000, 5'b00010,
                                     5'b11111, 5'b00000, 5'b00001});

        // Frame 1: brightness 2, ready high; a mid-frame start and brightness change are ignored.
        start_frame(4'd2);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("b2_f10", filter[1][0], 5'b00100);
        chk("b2_f12", filter[1][2], 5'b11100);
        repeat (12) @(posedge clk);
        #1 start = 1'b1;
        brightness = 4'd9;
        @(posedge clk);
        #1 start = 1'b0;
        wait_frame(1);
        repeat (5) @(posedge clk);
        chk("frame1_count", frames, 1);
        chk("frame1_enables", en_idx, NWIN);
        chk("frame1_results", res_idx, NWIN);
        chk("idle_busy", busy, 0);

        // Frame 2: brightness 0 -> 1, 4-cycle stall on the first result.
        result_ready = 1'b0;
        start_frame(4'd0);
        @(negedge clk);
        chk("b0_f10", filter[1][0], 5'b00010);
        chk("b0_f12", filter[1][2], 5'b11110);
        wait_valid();
        repeat (4) @(posedge clk);
        #1 result_ready = 1'b1;
        wait_frame(2);

        // Frame 3: brightness 15 -> 7, reset during WAIT of window 4, then a clean rerun.
        start_frame(4'd15);
        @(negedge clk);
        chk("b15_f10", filter[1][0], 5'b01110);
        chk("b15_f12", filter[1][2], 5'b10010);
        seen = 0;
        for (int i = 0; i < 500 && seen < 4; i++) begin
            @(negedge clk);
            if (calc_enable) seen++;
        end
        chk("enable4_timeout", seen, 4);
        @(posedge clk);
        @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_win", {win_row, win_col}, 0);
        chk("rst_result_data", result_data, 0);
        chk("rst_tags", {result_row, result_col}, 0);
        chk("rst_filter", filter, SOBEL_X_BASE);
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) @(posedge clk);
        chk("no_done_after_reset", frames, 2);
        start_frame(4'd15);
        wait_frame(3);

`ifdef X_CONV_SCHED_TIMEOUT_EN
        // Frame 4: x_conv never answers; every window times out after 16 WAIT cycles.
        hang = 1'b1;
        start_frame(4'd4);
        seen = 0;
        for (int i = 0; i < 100 && !calc_enable; i++) @(negedge clk);
        for (int i = 0; i < 100 && !result_valid; i++) begin
            @(negedge clk);
            seen++;
        end
        chk("timeout_latency", seen, 18);
        chk("timeout_data", result_data, 0);
        chk("timeout_err_set", timeout_err, 1);
        wait_frame(4);
        hang = 1'b0;
        start_frame(4'd2);
        @(negedge clk);
        chk("timeout_err_clear", timeout_err, 0);
        wait_frame(5);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
